// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the mode_counter family.
//   mode_t  : counting mode encoding as seen on the 2-bit mode input
//   DIR_UP / DIR_DOWN : direction encoding used on dir, dir_q and the
//                       internal bounce direction register
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary-to-Gray encoder.
// Ports:
//   bin  : binary input, WIDTH bits
//   gray : Gray-coded output, gray = bin ^ (bin >> 1)
module bin2gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/mode_counter.sv
// mode_counter: parametrised up/down counter with wrap, saturate, bounce and
// hold modes, synchronous parallel load and a combinational terminal-count flag.
// Optional feature macro: MODE_COUNTER_GRAY_EN adds the q_gray output.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset (q=0, bounce direction=up)
//   en       : count enable
//   dir      : 1 = up, 0 = down (ignored in bounce mode)
//   mode     : 00 wrap, 01 saturate, 10 bounce, 11 hold
//   load     : synchronous load of min(load_val, MODULUS-1); beats en
//   load_val : load value
//   q        : current count
//   dir_q    : effective direction of the next step
//   tc       : q sits on the boundary of the effective direction while counting
//   q_gray   : Gray-coded q (MODE_COUNTER_GRAY_EN only)
module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
`ifdef MODE_COUNTER_GRAY_EN
  output logic [WIDTH-1:0] q_gray,
`endif
  output logic             dir_q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  mode_t            mode_e;
  logic             bounce_dir;
  logic             bounce_dir_nxt;
  logic             at_bound;
  logic             step_dir;
  logic             stepping;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] load_clamped;

  assign mode_e = mode_t'(mode);

  assign dir_q    = (mode_e == MODE_BOUNCE) ? bounce_dir : dir;
  assign at_bound = (dir_q == DIR_UP) ? (q == MAX) : (q == ZERO);
  assign stepping = en && !load && (mode_e != MODE_HOLD);
  assign tc       = stepping && at_bound;

  assign load_clamped = (load_val > MAX) ? MAX : load_val;

  // A bounce counter normally never sits on the boundary of its own
  // direction (it flips on arrival), but a load or mode change can put it
  // there; in that case reverse instead of stepping past the range.
  assign step_dir = (mode_e == MODE_BOUNCE && at_bound) ? ~bounce_dir : dir_q;
  assign q_step   = (step_dir == DIR_UP) ? q + 1'b1 : q - 1'b1;

  always_comb begin
    q_nxt          = q;
    bounce_dir_nxt = bounce_dir;
    if (load) begin
      q_nxt = load_clamped;
    end else if (stepping) begin
      case (mode_e)
        MODE_WRAP: begin
          if (at_bound) q_nxt = (dir_q == DIR_UP) ? ZERO : MAX;
          else          q_nxt = q_step;
        end
        MODE_SAT: begin
          if (!at_bound) q_nxt = q_step;
        end
        MODE_BOUNCE: begin
          q_nxt = q_step;
          // Flip on arrival so the boundary value is emitted exactly once.
          if (q_step == MAX)       bounce_dir_nxt = DIR_DOWN;
          else if (q_step == ZERO) bounce_dir_nxt = DIR_UP;
          else                     bounce_dir_nxt = step_dir;
        end
        default: q_nxt = q;
      endcase
    end
  end

  // Count and bounce direction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q          <= '0;
      bounce_dir <= DIR_UP;
    end else begin
      q          <= q_nxt;
      bounce_dir <= bounce_dir_nxt;
    end
  end

`ifdef MODE_COUNTER_GRAY_EN
  bin2gray #(.WIDTH(WIDTH)) u_gray (
    .bin  (q),
    .gray (q_gray)
  );
`endif

endmodule
